// File: rtl/keypad_pkg.sv
// Key-code mapping and FSM state type shared by the keypad emulator and the
// scanner/decoder path.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HELD,
        BOUNCE_OUT,
        GAP
    } kp_state_t;

    localparam logic [3:0] COL_IDLE = 4'hF;

    function automatic logic [1:0] key_row(input logic [3:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/keypad_emulator_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting toward the MSB,
// used as the contact-chatter source.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder: one emulated key press with optional chatter,
// driving active-low columns from the scanner's active-low row selects.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES    = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  key_code,
    input  logic [15:0] hold_len,
    input  logic        bounce_en,
    input  logic [3:0]  r_sel,
    output logic [3:0]  col,
    output logic        busy,
    output logic        done,
    output logic        contact
);

    localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);

    kp_state_t   state;
    logic [15:0] cnt;
    logic [3:0]  key_q;
    logic [15:0] hold_load_q;
    logic        bounce_q;
    logic        start;
    logic [15:0] hold_load;
    logic        lfsr_en;
    logic [15:0] lfsr_q;

    assign start     = req && !done;
    assign hold_load = (hold_len == 16'd0) ? 16'd0 : hold_len - 16'd1;

    // Advance on every edge that enters or stays in a bounce phase, so that in
    // each bounce cycle the registered contact equals that cycle's LFSR bit 0.
    always_comb begin
        lfsr_en = 1'b0;
        case (state)
            IDLE:       lfsr_en = start && bounce_en;
            BOUNCE_IN:  lfsr_en = (cnt != 16'd0);
            HELD:       lfsr_en = (cnt == 16'd0) && bounce_q;
            BOUNCE_OUT: lfsr_en = (cnt != 16'd0);
            default:    lfsr_en = 1'b0;
        endcase
    end

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (lfsr_en),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_q       <= '0;
            hold_load_q <= '0;
            bounce_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            contact     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q       <= key_code;
                        hold_load_q <= hold_load;
                        bounce_q    <= bounce_en;
                        busy        <= 1'b1;
                        if (bounce_en) begin
                            state   <= BOUNCE_IN;
                            cnt     <= BOUNCE_LOAD;
                            contact <= lfsr_q[0];
                        end else begin
                            state   <= HELD;
                            cnt     <= hold_load;
                            contact <= 1'b1;
                        end
                    end
                end
                BOUNCE_IN: begin
                    if (cnt == 16'd0) begin
                        state   <= HELD;
                        cnt     <= hold_load_q;
                        contact <= 1'b1;
                    end else begin
                        cnt     <= cnt - 16'd1;
                        contact <= lfsr_q[0];
                    end
                end
                HELD: begin
                    if (cnt == 16'd0) begin
                        if (bounce_q) begin
                            state   <= BOUNCE_OUT;
                            cnt     <= BOUNCE_LOAD;
                            contact <= lfsr_q[0];
                        end else begin
                            state   <= GAP;
                            cnt     <= GAP_LOAD;
                            contact <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                BOUNCE_OUT: begin
                    if (cnt == 16'd0) begin
                        state   <= GAP;
                        cnt     <= GAP_LOAD;
                        contact <= 1'b0;
                    end else begin
                        cnt     <= cnt - 16'd1;
                        contact <= lfsr_q[0];
                    end
                end
                GAP: begin
                    if (cnt == 16'd0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        col = COL_IDLE;
        if (contact && !r_sel[key_row(key_q)]) begin
            col[key_col(key_q)] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed and randomized presses
// compared cycle by cycle against a per-press expected contact trace.
module tb_keypad_emulator;

    localparam int          NB   = 16;
    localparam int          NG   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [3:0]  key_code;
    logic [15:0] hold_len;
    logic        bounce_en;
    logic [3:0]  r_sel;
    logic [3:0]  col;
    logic        busy;
    logic        done;
    logic        contact;

    int checks = 0;
    int errors = 0;
    int rot_i  = 0;
    logic [15:0] m_lfsr = SEED;
    logic [3:0]  rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_emulator #(
        .BOUNCE_CYCLES (NB),
        .GAP_CYCLES    (NG),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .key_code  (key_code),
        .hold_len  (hold_len),
        .bounce_en (bounce_en),
        .r_sel     (r_sel),
        .col       (col),
        .busy      (busy),
        .done      (done),
        .contact   (contact)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1 written as plain shift arithmetic.
    function automatic logic [15:0] step(input logic [15:0] l);
        int unsigned v;
        int unsigned fb;
        v  = l;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 32'hFFFF);
    endfunction

    function automatic logic [3:0] exp_col(input logic [3:0] k, input logic [3:0] rs, input bit c);
        logic [3:0] v;
        int row;
        int cc;
        v   = 4'hF;
        row = k / 4;
        cc  = k % 4;
        if (c && rs[row] == 1'b0) v[cc] = 1'b0;
        return v;
    endfunction

    function automatic logic [3:0] pick(input int mode, input logic [3:0] fixed);
        logic [3:0] v;
        if (mode == 0) v = fixed;
        else if (mode == 1) begin
            v = rot[rot_i % 4];
            rot_i++;
        end else v = 4'($urandom);
        return v;
    endfunction

    task automatic run_press(input logic [3:0] k, input logic [15:0] h, input bit b,
                             input int mode, input logic [3:0] fixed,
                             input bit noise, input bit chain);
        bit exp_c[$];
        int hh;
        logic [3:0] rs;
        hh = (h == 16'd0) ? 1 : int'(h);
        if (b) for (int i = 0; i < NB; i++) begin exp_c.push_back(m_lfsr[0]); m_lfsr = step(m_lfsr); end
        for (int i = 0; i < hh; i++) exp_c.push_back(1'b1);
        if (b) for (int i = 0; i < NB; i++) begin exp_c.push_back(m_lfsr[0]); m_lfsr = step(m_lfsr); end
        for (int i = 0; i < NG; i++) exp_c.push_back(1'b0);

        req = 1'b1; key_code = k; hold_len = h; bounce_en = b;
        tick();
        req = 1'b0;
        for (int i = 0; i < exp_c.size(); i++) begin
            if (noise) begin
                req = 1'($urandom); key_code = 4'($urandom);
                hold_len = 16'($urandom); bounce_en = 1'($urandom);
            end
            if (i == exp_c.size() - 1) begin
                req = chain; key_code = k; hold_len = h; bounce_en = b;
            end
            rs = pick(mode, fixed);
            r_sel = rs;
            #1;
            chk("col", 16'(col), 16'(exp_col(k, rs, exp_c[i])));
            chk("contact", 16'(contact), 16'(exp_c[i]));
            chk("busy", 16'(busy), 16'd1);
            chk("done_low", 16'(done), 16'd0);
            tick();
        end
        rs = pick(mode, fixed);
        r_sel = rs;
        #1;
        chk("done_pulse", 16'(done), 16'd1);
        chk("busy_end", 16'(busy), 16'd0);
        chk("col_end", 16'(col), 16'hF);
        if (!chain) req = 1'b0;
        tick();
        chk("done_one", 16'(done), 16'd0);
        chk("busy_idle", 16'(busy), 16'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; key_code = '0; hold_len = '0;
        bounce_en = 1'b0; r_sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_col", 16'(col), 16'hF);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_done", 16'(done), 16'd0);
            chk("rst_contact", 16'(contact), 16'd0);
        end
        reset = 1'b0;
        m_lfsr = SEED;
        tick();

        // Clean press, key 6 (row 1, col 2), row 1 selected.
        run_press(4'h6, 16'd10, 1'b0, 0, 4'b1101, 1'b0, 1'b0);
        // Scan match, key B against rotating row selects.
        run_press(4'hB, 16'd12, 1'b0, 1, 4'hF, 1'b0, 1'b0);
        // Chatter in both phases.
        run_press(4'h3, 16'd5, 1'b1, 2, 4'hF, 1'b0, 1'b0);
        run_press(4'h9, 16'd7, 1'b1, 0, 4'b1011, 1'b0, 1'b0);
        // Inputs and req toggled while busy must be ignored.
        run_press(4'hA, 16'd8, 1'b0, 0, 4'b1011, 1'b1, 1'b0);
        run_press(4'hA, 16'd6, 1'b1, 2, 4'hF, 1'b1, 1'b0);
        // hold_len 0 behaves as 1.
        run_press(4'hF, 16'd0, 1'b0, 0, 4'b0111, 1'b0, 1'b0);
        // req held through the done cycle: ignored then, accepted one cycle later.
        run_press(4'h1, 16'd3, 1'b0, 0, 4'b1110, 1'b0, 1'b1);
        run_press(4'h1, 16'd3, 1'b0, 0, 4'b1110, 1'b0, 1'b0);

        // Reset mid-HELD with key 5 visible on row 1.
        r_sel = 4'b1101; req = 1'b1; key_code = 4'h5; hold_len = 16'd20; bounce_en = 1'b0;
        tick();
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_col", 16'(col), 16'(4'b1101));
            tick();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_col", 16'(col), 16'hF);
            chk("abort_busy", 16'(busy), 16'd0);
            chk("abort_done", 16'(done), 16'd0);
        end
        reset = 1'b0;
        m_lfsr = SEED;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("post_abort_done", 16'(done), 16'd0);
            chk("post_abort_col", 16'(col), 16'hF);
        end

        for (int n = 0; n < 20; n++) begin
            run_press(4'($urandom), 16'($urandom_range(0, 20)), 1'($urandom),
                      2, 4'hF, 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
